conv3x3_prog_filter: RTL and testbench
======================================

// Module: conv3x3_prog_filter
// PURPOSE
//  Parametrised 3x3 convolution engine, successor to the fixed box filter. Takes one
//  packed 3x3 window per cycle from the line-buffer stage and emits one filtered pixel
//  after a fixed 4-cycle latency. Adds programmable signed coefficients (double-buffered),
//  selectable modes (box / custom / abs / pass-through), rounding shift and saturation.
// PARAMETERS
//  PIXEL_W  8  unsigned pixel width, input taps and output
//  COEF_W   8  signed coefficient width (two's complement)
//  SHIFT_W  5  width of normalisation shift control
// PORTS
//  i_clk                   in   1            clock, all logic on rising edge
//  i_rst                   in   1            reset, asynchronous, active-high
//  i_pixel_data            in   9*PIXEL_W    window taps, tap k at [k*PIXEL_W +: PIXEL_W], k=4 centre
//  i_pixel_data_valid      in   1            window valid this cycle
//  i_mode                  in   2            0 box, 1 custom, 2 abs, 3 pass-through
//  i_norm_shift            in   SHIFT_W      right shift for modes 1/2
//  i_coef_wr_en            in   1            write shadow coefficient
//  i_coef_wr_addr          in   4            shadow index 0..8; 9..15 ignored
//  i_coef_wr_data          in   COEF_W       signed coefficient value
//  i_coef_commit           in   1            copy shadow bank to active bank
//  o_convolved_data        out  PIXEL_W      filtered pixel
//  o_convolved_data_valid  out  1            output valid
//  o_sat                   out  1            output was clamped (qualified by valid)
// BEHAVIOUR
//  - Reset: active and shadow coefs all = +1; all pipeline regs, outputs, o_sat, valid = 0.
//    Asserting i_rst mid-stream flushes pipeline immediately; no valid until 4 cycles
//    after the first accepted window post-reset.
//  - Pipeline, advances every cycle (no stall): S1 register 9 signed products + mode/shift/
//    centre tap; S2 three row partial sums; S3 full sum; S4 normalise, saturate, output.
//    Valid shifts alongside; window accepted at edge N appears valid at edge N+4. Bubbles
//    preserved; back-to-back windows give back-to-back outputs.
//  - Mode and shift sampled in S1 with the data; changes apply per sample, no glitch.
//  - Widths: product = PIXEL_W+COEF_W+1 signed (pixel zero-extended); sum = product+4 bits.
//  - Mode 0 box: coefs ignored, sum of taps, result = floor(sum/9) via constant-reciprocal
//    multiply, bit-exact for all sums 0..9*(2^PIXEL_W-1); never saturates, o_sat=0.
//  - Mode 1 custom: s = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (arithmetic);
//    clamp to [0, 2^PIXEL_W-1]; o_sat=1 iff clamped.
//  - Mode 2 abs: same as mode 1 on |sum|; only upper clamp possible.
//  - Mode 3 pass-through: centre tap delayed 4 cycles; o_sat=0.
//  - Coef bank: writes go to shadow only. Commit copies shadow->active at that edge;
//    window accepted in the same cycle uses old active set, next window the new set.
//    Write and commit same cycle to same index: new value included in commit (write-first).
//    In-flight samples never affected by commit (products already registered).
// STRUCTURE
//  - Package conv_pkg: mode encodings (MODE_BOX/CUSTOM/ABS/PASS), tap count 9, centre
//    index 4, width functions for product/sum, box reciprocal constant function.
//  - Sub-module conv_coef_bank: shadow/active registers, write port, commit, reset to +1,
//    outputs flat 9*COEF_W active vector. Datapath and valid pipe stay in top.
// TESTING
//  1. Reset then mode 0, all taps 255, valid 1 cycle -> 4 cycles later data 255, sat 0.
//  2. Mode 0, taps 0..8 -> 4 (36/9); sweep all sums 0..2295 vs floor(sum/9), no mismatch.
//  3. Load Laplacian (centre +8, others -1), commit, mode 1 shift 0, flat 100 window -> 0;
//     centre 200 others 0 -> 255, sat 1; centre 0 others 50 -> 0, sat 1.
//  4. Mode 2 Sobel-x coefs, shift 2: left col 0 right col 200 -> |800|>>2 = 200, sat 0.
//  5. Commit asserted mid continuous stream -> outputs switch exactly on window after
//     commit cycle; shadow write to addr 12 leaves both banks unchanged.
//  6. Stream with bubbles, i_rst pulsed mid-stream -> valid drops immediately, no stale
//     outputs, coefs back to +1; mode 3 returns centre tap with 4-cycle delay.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, mode encodings and width helpers for the 3x3 convolution engine.
package conv_pkg;

    localparam int unsigned TAPS   = 9;
    localparam int unsigned CENTRE = 4;

    typedef enum logic [1:0] {
        MODE_BOX    = 2'd0,
        MODE_CUSTOM = 2'd1,
        MODE_ABS    = 2'd2,
        MODE_PASS   = 2'd3
    } mode_e;

    // Pixel is zero-extended by one bit so the product stays signed.
    function automatic int unsigned prod_w(int unsigned pw, int unsigned cw);
        return pw + cw + 1;
    endfunction

    function automatic int unsigned sum_w(int unsigned pw, int unsigned cw);
        return prod_w(pw, cw) + 4;
    endfunction

    // Tap sum fits in pw+4 bits; 4 guard bits keep the reciprocal error below one LSB.
    function automatic int unsigned box_shift(int unsigned pw);
        return pw + 8;
    endfunction

    function automatic longint unsigned box_recip(int unsigned pw);
        return ((64'd1 << box_shift(pw)) + 64'd8) / 64'd9;
    endfunction

endpackage

// File: rtl/conv_coef_bank.sv
// Double-buffered signed coefficient store: writes land in the shadow bank,
// commit copies shadow to active (a same-cycle write is included).
module conv_coef_bank
    import conv_pkg::*;
#(
    parameter int unsigned COEF_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [3:0]               i_wr_addr,
    input  logic [COEF_W-1:0]        i_wr_data,
    input  logic                     i_commit,
    output logic [TAPS*COEF_W-1:0]   o_active
);

    localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1);

    logic [COEF_W-1:0] r_shadow [TAPS];
    logic [COEF_W-1:0] r_active [TAPS];
    logic [TAPS-1:0]   w_hit;

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            w_hit[k] = i_wr_en && (i_wr_addr == 4'(k));
            o_active[k*COEF_W +: COEF_W] = r_active[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_shadow[k] <= COEF_ONE;
                r_active[k] <= COEF_ONE;
            end
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (w_hit[k]) r_shadow[k] <= i_wr_data;
                if (i_commit) r_active[k] <= w_hit[k] ? i_wr_data : r_shadow[k];
            end
        end
    end

endmodule

// File: rtl/conv3x3_prog_filter.sv
// Four-stage 3x3 convolution: products, row sums, total, then normalise/saturate.
// Modes: box average, custom coefficients, absolute custom, centre pass-through.
module conv3x3_prog_filter
    import conv_pkg::*;
#(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned COEF_W  = 8,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [TAPS*PIXEL_W-1:0]   i_pixel_data,
    input  logic                      i_pixel_data_valid,
    input  logic [1:0]                i_mode,
    input  logic [SHIFT_W-1:0]        i_norm_shift,
    input  logic                      i_coef_wr_en,
    input  logic [3:0]                i_coef_wr_addr,
    input  logic [COEF_W-1:0]         i_coef_wr_data,
    input  logic                      i_coef_commit,
    output logic [PIXEL_W-1:0]        o_convolved_data,
    output logic                      o_convolved_data_valid,
    output logic                      o_sat
);

    localparam int unsigned PROD_W  = prod_w(PIXEL_W, COEF_W);
    localparam int unsigned SUM_W   = sum_w(PIXEL_W, COEF_W);
    localparam int unsigned BOX_W   = PIXEL_W + 4;
    localparam int unsigned BOX_K   = box_shift(PIXEL_W);
    localparam int unsigned BOX_M_W = BOX_K - 2;
    localparam int unsigned BOX_P_W = BOX_W + BOX_M_W;
    // Wide enough that the rounding term for the largest shift cannot overflow.
    localparam int unsigned RND_W   = SUM_W + (2 ** SHIFT_W) + 1;

    localparam logic [BOX_M_W-1:0]      BOX_M   = BOX_M_W'(box_recip(PIXEL_W));
    localparam logic signed [RND_W-1:0] PIX_MAX = RND_W'((2 ** PIXEL_W) - 1);

    logic [TAPS*COEF_W-1:0]   w_active;
    logic [COEF_W-1:0]        w_coef [TAPS];
    logic signed [PROD_W-1:0] w_prod [TAPS];

    logic signed [PROD_W-1:0] r1_prod [TAPS];
    logic signed [SUM_W-1:0]  r2_row [3];
    logic signed [SUM_W-1:0]  r3_sum;
    mode_e                    r1_mode, r2_mode, r3_mode;
    logic [SHIFT_W-1:0]       r1_shift, r2_shift, r3_shift;
    logic [PIXEL_W-1:0]       r1_centre, r2_centre, r3_centre;
    logic                     r1_valid, r2_valid, r3_valid;
    logic [PIXEL_W-1:0]       r4_data;
    logic                     r4_sat, r4_valid;

    logic signed [RND_W-1:0]  w_ext, w_mag, w_rnd, w_shifted;
    logic [BOX_P_W-1:0]       w_box_prod;
    logic [PIXEL_W-1:0]       w_box_q, w_data;
    logic                     w_sat;

    conv_coef_bank #(
        .COEF_W    (COEF_W)
    ) u_coef_bank (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_coef_wr_en),
        .i_wr_addr (i_coef_wr_addr),
        .i_wr_data (i_coef_wr_data),
        .i_commit  (i_coef_commit),
        .o_active  (w_active)
    );

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            w_coef[k] = (i_mode == MODE_BOX) ? COEF_W'(1) : w_active[k*COEF_W +: COEF_W];
            w_prod[k] = PROD_W'($signed({1'b0, i_pixel_data[k*PIXEL_W +: PIXEL_W]}))
                      * PROD_W'($signed(w_coef[k]));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < TAPS; k++) r1_prod[k] <= '0;
            for (int r = 0; r < 3; r++) r2_row[r] <= '0;
            r3_sum    <= '0;
            r1_mode   <= MODE_BOX;
            r2_mode   <= MODE_BOX;
            r3_mode   <= MODE_BOX;
            r1_shift  <= '0;
            r2_shift  <= '0;
            r3_shift  <= '0;
            r1_centre <= '0;
            r2_centre <= '0;
            r3_centre <= '0;
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            r4_data   <= '0;
            r4_sat    <= 1'b0;
            r4_valid  <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++) r1_prod[k] <= w_prod[k];
            r1_mode   <= mode_e'(i_mode);
            r1_shift  <= i_norm_shift;
            r1_centre <= i_pixel_data[CENTRE*PIXEL_W +: PIXEL_W];
            r1_valid  <= i_pixel_data_valid;

            for (int r = 0; r < 3; r++) begin
                r2_row[r] <= SUM_W'(r1_prod[3*r]) + SUM_W'(r1_prod[3*r+1])
                           + SUM_W'(r1_prod[3*r+2]);
            end
            r2_mode   <= r1_mode;
            r2_shift  <= r1_shift;
            r2_centre <= r1_centre;
            r2_valid  <= r1_valid;

            r3_sum    <= r2_row[0] + r2_row[1] + r2_row[2];
            r3_mode   <= r2_mode;
            r3_shift  <= r2_shift;
            r3_centre <= r2_centre;
            r3_valid  <= r2_valid;

            r4_data   <= w_data;
            r4_sat    <= w_sat;
            r4_valid  <= r3_valid;
        end
    end

    always_comb begin
        w_ext      = RND_W'(r3_sum);
        w_mag      = (r3_mode == MODE_ABS && r3_sum[SUM_W-1]) ? -w_ext : w_ext;
        w_rnd      = (r3_shift != '0) ? (RND_W'(1) << (r3_shift - 1'b1)) : '0;
        w_shifted  = (w_mag + w_rnd) >>> r3_shift;
        // floor(sum/9) as multiply by a rounded-up reciprocal of 9.
        w_box_prod = BOX_P_W'(r3_sum[BOX_W-1:0]) * BOX_P_W'(BOX_M);
        w_box_q    = PIXEL_W'(w_box_prod >> BOX_K);

        w_data = '0;
        w_sat  = 1'b0;
        case (r3_mode)
            MODE_BOX:  w_data = w_box_q;
            MODE_PASS: w_data = r3_centre;
            default: begin
                if (w_shifted[RND_W-1]) begin
                    w_sat = 1'b1;
                end else if (w_shifted > PIX_MAX) begin
                    w_data = '1;
                    w_sat  = 1'b1;
                end else begin
                    w_data = w_shifted[PIXEL_W-1:0];
                end
            end
        endcase
    end

    assign o_convolved_data       = r4_data;
    assign o_convolved_data_valid = r4_valid;
    assign o_sat                  = r4_sat;

endmodule

// File: tb/tb_conv3x3_prog_filter.sv
// Directed and randomized bench for conv3x3_prog_filter against an arithmetic
// reference model with a 4-deep expected-result pipe.
module tb_conv3x3_prog_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] pix;
    logic        pvld;
    logic [1:0]  mode;
    logic [4:0]  shift;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        commit;
    logic [7:0]  od;
    logic        ov;
    logic        os;

    int n_cmp = 0;
    int n_bad = 0;

    int m_sh  [9];
    int m_act [9];
    bit p_v [4];
    int p_d [4];
    bit p_s [4];

    always #5 clk = ~clk;

    conv3x3_prog_filter #(
        .PIXEL_W                (8),
        .COEF_W                 (8),
        .SHIFT_W                (5)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_pixel_data           (pix),
        .i_pixel_data_valid     (pvld),
        .i_mode                 (mode),
        .i_norm_shift           (shift),
        .i_coef_wr_en           (wr_en),
        .i_coef_wr_addr         (wr_addr),
        .i_coef_wr_data         (wr_data),
        .i_coef_commit          (commit),
        .o_convolved_data       (od),
        .o_convolved_data_valid (ov),
        .o_sat                  (os)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Convolution result of the window currently on the inputs.
    task automatic model_eval(output int d, output bit s);
        longint sum;
        longint r;
        int     t;
        sum = 0;
        for (int k = 0; k < 9; k++) begin
            t = int'(pix[k*8 +: 8]);
            sum += longint'(t) * longint'((mode == 2'd0) ? 1 : m_act[k]);
        end
        s = 1'b0;
        d = 0;
        case (mode)
            2'd0: d = int'(sum / 9);
            2'd3: d = int'(pix[39:32]);
            default: begin
                if (mode == 2'd2 && sum < 0) sum = -sum;
                r = sum + ((shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0);
                r = r >>> shift;
                if (r < 0) begin
                    d = 0;
                    s = 1'b1;
                end else if (r > 255) begin
                    d = 255;
                    s = 1'b1;
                end else begin
                    d = int'(r);
                end
            end
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            p_v[i] = 1'b0;
            p_d[i] = 0;
            p_s[i] = 1'b0;
        end
        for (int k = 0; k < 9; k++) begin
            m_sh[k]  = 1;
            m_act[k] = 1;
        end
    endtask

    // One clock: model the edge, then compare outputs 1ns after it.
    task automatic tick();
        int ed;
        bit es;
        bit ev;
        model_eval(ed, es);
        ev = pvld && !rst;
        @(posedge clk);
        for (int i = 3; i > 0; i--) begin
            p_v[i] = p_v[i-1];
            p_d[i] = p_d[i-1];
            p_s[i] = p_s[i-1];
        end
        p_v[0] = ev;
        p_d[0] = ed;
        p_s[0] = es;
        if (rst) begin
            model_reset();
        end else begin
            if (commit)
                for (int k = 0; k < 9; k++)
                    m_act[k] = (wr_en && wr_addr == 4'(k)) ? int'($signed(wr_data)) : m_sh[k];
            if (wr_en && wr_addr < 4'd9) m_sh[wr_addr] = int'($signed(wr_data));
        end
        #1;
        chk("valid", 32'(ov), 32'(p_v[3]));
        if (p_v[3]) begin
            chk("data", 32'(od), 32'(p_d[3]));
            chk("sat", 32'(os), 32'(p_s[3]));
        end
    endtask

    function automatic logic [71:0] flat(input int c, input int o);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'((k == 4) ? c : o);
        return w;
    endfunction

    function automatic logic [71:0] cols(input int l, input int m, input int r);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'((k % 3 == 0) ? l : ((k % 3 == 1) ? m : r));
        return w;
    endfunction

    function automatic logic [71:0] rnd_win();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    // Single window followed by three bubbles; check the result against constants.
    task automatic apply_check(input string tag, input logic [71:0] w, input int ed, input bit es);
        pix  = w;
        pvld = 1'b1;
        tick();
        pvld = 1'b0;
        repeat (3) tick();
        chk({tag, "_v"}, 32'(ov), 32'd1);
        chk({tag, "_d"}, 32'(od), 32'(ed));
        chk({tag, "_s"}, 32'(os), 32'(es));
    endtask

    task automatic load_coef(input int k, input int v, input bit do_commit);
        wr_en   = 1'b1;
        wr_addr = 4'(k);
        wr_data = 8'(v);
        commit  = do_commit;
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    initial begin
        int rem;
        int t;
        int c;
        model_reset();
        rst = 1'b1; pix = '0; pvld = 1'b0; mode = 2'd0; shift = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        #1;
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_data", 32'(od), 32'd0);
        chk("rst_sat", 32'(os), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Box mode basics and exhaustive sum sweep
        apply_check("box_255", flat(255, 255), 255, 1'b0);
        apply_check("box_0to8", 72'h08_07_06_05_04_03_02_01_00, 4, 1'b0);
        pvld = 1'b1;
        for (int s = 0; s <= 2295; s++) begin
            rem = s;
            for (int k = 0; k < 9; k++) begin
                t = (rem > 255) ? 255 : rem;
                pix[k*8 +: 8] = 8'(t);
                rem -= t;
            end
            tick();
        end
        pvld = 1'b0;
        repeat (4) tick();

        // Laplacian in custom mode, commit on the last write
        for (int k = 0; k < 9; k++) load_coef(k, (k == 4) ? 8 : -1, k == 8);
        mode = 2'd1; shift = 5'd0;
        apply_check("lap_flat", flat(100, 100), 0, 1'b0);
        apply_check("lap_hi", flat(200, 0), 255, 1'b1);
        apply_check("lap_lo", flat(0, 50), 0, 1'b1);

        // Sobel-x in abs mode
        for (int k = 0; k < 9; k++) begin
            c = (k / 3 == 1) ? 2 : 1;
            load_coef(k, (k % 3 == 0) ? -c : ((k % 3 == 2) ? c : 0), 1'b0);
        end
        load_coef(12, 77, 1'b1);
        mode = 2'd2; shift = 5'd2;
        apply_check("sobel", cols(0, 77, 200), 200, 1'b0);

        // Commit mid continuous stream; addr 12 write must be ignored
        mode = 2'd1; shift = 5'd3; pvld = 1'b1;
        for (int i = 0; i < 24; i++) begin
            pix     = rnd_win();
            wr_en   = (i < 10);
            wr_addr = (i == 9) ? 4'd12 : 4'(i);
            wr_data = 8'($urandom_range(0, 255));
            commit  = (i == 12);
            tick();
        end
        wr_en = 1'b0; commit = 1'b0; pvld = 1'b0;
        repeat (4) tick();

        // Random modes, shifts, bubbles and coefficient traffic
        for (int i = 0; i < 400; i++) begin
            pix     = rnd_win();
            pvld    = ($urandom_range(0, 3) != 0);
            mode    = 2'($urandom_range(0, 3));
            shift   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(0, 6));
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 8'($urandom_range(0, 255));
            commit  = ($urandom_range(0, 9) == 0);
            tick();
        end
        wr_en = 1'b0; commit = 1'b0;

        // Reset pulse mid-stream, then pass-through with bubbles
        mode = 2'd1; shift = 5'd1; pvld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix = rnd_win();
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ov), 32'd0);
        tick();
        rst = 1'b0;
        pvld = 1'b0;
        tick();
        mode = 2'd1; shift = 5'd0;
        apply_check("rst_coef_one", flat(10, 10), 90, 1'b0);
        mode = 2'd3;
        for (int i = 0; i < 30; i++) begin
            pix  = rnd_win();
            pvld = ($urandom_range(0, 2) != 0);
            tick();
        end
        pvld = 1'b0;
        repeat (4) tick();
        apply_check("pass", flat(173, 9), 173, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
